// File: rtl/trig_counter.sv
// ---------------------------------------------------------------------------
// trig_counter
//
// Up/down event counter driven by an asynchronous, possibly bouncing trigger.
// The trigger is brought into the clk domain through a two-flop synchronizer.
// It is optionally debounced. Each rising edge of the resulting filtered level
// is one step event. A step event moves the counter by one when en is high.
// At the count limits the counter either wraps or holds, as set by SATURATE.
//
// Optional feature:
//   TRIG_COUNTER_DEBOUNCE_EN  defined   -> debounce filter compiled in. The
//                                          filtered level follows the
//                                          synchronized trigger only after
//                                          DEB_CYCLES consecutive mismatches.
//                             undefined -> filtered level is the synchronized
//                                          trigger. DEB_CYCLES is unused.
//
// Parameters:
//   WIDTH      counter width (2..32)
//   MAX_VAL    terminal count (1..2**WIDTH-1)
//   DEB_CYCLES debounce stability window in clk cycles (2..65535)
//   SATURATE   0 = wrap at the limits, 1 = hold at the limits
//
// Ports:
//   clk       in   clock, rising edge active
//   rst_n     in   synchronous active-low reset
//   trigger   in   asynchronous count request
//   en        in   count enable
//   up        in   direction: 1 = up, 0 = down
//   load      in   synchronous load strobe; has priority over a step
//   load_val  in   load value, clamped to MAX_VAL
//   count     out  registered counter value
//   tc        out  terminal count for the current direction (combinational)
//   wrap      out  one-cycle pulse after a wrap-around
//   step      out  one-cycle pulse after every accepted trigger edge
// ---------------------------------------------------------------------------
module trig_counter #(
   parameter int unsigned     WIDTH      = 8,
   parameter longint unsigned MAX_VAL    = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     DEB_CYCLES = 16,
   parameter int unsigned     SATURATE   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trigger,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             step
);

   localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   localparam bit PARAMS_OK = (WIDTH >= 2) && (WIDTH <= 32) &&
                              (MAX_VAL >= 64'd1) &&
                              (MAX_VAL <= ((64'd1 << WIDTH) - 64'd1)) &&
                              (DEB_CYCLES >= 2) && (DEB_CYCLES <= 65535);

   // An out-of-range configuration is visible as this named scope in the
   // elaborated hierarchy.
   if (!PARAMS_OK) begin : g_illegal_params
   end

   // Next count for one step in direction dir. The MSB of the result flags a
   // wrap-around. With SATURATE set, the count holds at the limit and never wraps.
   function automatic logic [WIDTH:0] step_value(input logic [WIDTH-1:0] cur,
                                                 input logic             dir);
      logic [WIDTH:0] r;
      if (dir) begin
         if (cur == MAX_C)
            r = (SATURATE != 0) ? {1'b0, cur} : {1'b1, {WIDTH{1'b0}}};
         else
            r = {1'b0, cur + ONE};
      end else begin
         if (cur == '0)
            r = (SATURATE != 0) ? {1'b0, cur} : {1'b1, MAX_C};
         else
            r = {1'b0, cur - ONE};
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX_C) ? MAX_C : v;
   endfunction

   logic             sync1_q;
   logic             sync2_q;
   logic             filt;
   logic             filt_prev_q;
   logic             step_ev;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             step_q, step_d;
   logic [WIDTH:0]   stepped;

`ifdef TRIG_COUNTER_DEBOUNCE_EN
   logic        filt_q, filt_d;
   logic [15:0] stab_q, stab_d;

   // The stability counter counts consecutive edges on which the synchronized
   // trigger disagrees with the filtered level. Any agreeing sample restarts it.
   always_comb begin
      filt_d = filt_q;
      stab_d = '0;
      if (sync2_q != filt_q) begin
         if (stab_q == 16'(DEB_CYCLES - 1)) begin
            filt_d = sync2_q;
            stab_d = '0;
         end else begin
            stab_d = stab_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         stab_q <= '0;
      end else begin
         filt_q <= filt_d;
         stab_q <= stab_d;
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync2_q;
`endif

   // A step event is a rising edge of the filtered level.
   assign step_ev = filt & ~filt_prev_q;
   assign stepped = step_value(count_q, up);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      step_d  = step_ev;
      if (load) begin
         count_d = clamp_load(load_val);
      end else if (step_ev && en) begin
         count_d = stepped[WIDTH-1:0];
         wrap_d  = stepped[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         filt_prev_q <= 1'b0;
         count_q     <= '0;
         wrap_q      <= 1'b0;
         step_q      <= 1'b0;
      end else begin
         sync1_q     <= trigger;
         sync2_q     <= sync1_q;
         filt_prev_q <= filt;
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         step_q      <= step_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign step  = step_q;
   assign tc    = up ? (count_q == MAX_C) : (count_q == '0);

endmodule

// File: tb/tb_trig_counter.sv
// ---------------------------------------------------------------------------
// tb_trig_counter
//
// Drives two counters (wrapping and saturating, WIDTH=4, MAX_VAL=9,
// DEB_CYCLES=4) from shared stimulus. Expected {wrap, count} for the wrapping
// counter are queued as each trigger pulse is driven. They are checked
// whenever it pulses step. Latency and saturating behaviour are checked
// directly. The expected latency follows TRIG_COUNTER_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_trig_counter;

   localparam int W    = 4;
   localparam int MAXV = 9;
   localparam int DEB  = 4;
`ifdef TRIG_COUNTER_DEBOUNCE_EN
   localparam bit DEB_ON = 1'b1;
`else
   localparam bit DEB_ON = 1'b0;
`endif
   localparam int LAT = DEB_ON ? 3 + DEB : 3;

   logic         clk = 1'b0;
   logic         rst_n, trigger, en, up, load;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt_w, cnt_s;
   logic         tc_w, tc_s, wrap_w, wrap_s, step_w, step_s;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_step_w = 0, n_wrap_w = 0, n_step_s = 0, n_wrap_s = 0;
   logic [W:0] sb_q [$];

   always #5 clk = ~clk;

   trig_counter #(.WIDTH(W), .MAX_VAL(MAXV), .DEB_CYCLES(DEB), .SATURATE(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(cnt_w), .tc(tc_w), .wrap(wrap_w), .step(step_w));

   trig_counter #(.WIDTH(W), .MAX_VAL(MAXV), .DEB_CYCLES(DEB), .SATURATE(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(cnt_s), .tc(tc_s), .wrap(wrap_s), .step(step_s));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int h, input int l);
      trigger = 1'b1;
      tick(h);
      trigger = 1'b0;
      tick(l);
   endtask

   task automatic push(input logic [W-1:0] c, input logic w);
      sb_q.push_back({w, c});
   endtask

   // Scoreboard: each step pulse of the wrapping counter consumes one entry.
   always @(negedge clk) begin
      logic [W:0] e;
      if (step_w === 1'b1) begin
         n_step_w++;
         check("sb_step_expected", sb_q.size(), (sb_q.size() > 0) ? sb_q.size() : 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_count", cnt_w, e[W-1:0]);
            check("sb_wrap", wrap_w, e[W]);
         end
      end
      if (wrap_w === 1'b1) n_wrap_w++;
      if (step_s === 1'b1) n_step_s++;
      if (wrap_s === 1'b1) n_wrap_s++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ps;
      rst_n = 1'b0; trigger = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
      tick(3);
      check("rst_count_w", cnt_w, 0);
      check("rst_count_s", cnt_s, 0);
      check("rst_step", {step_w, step_s}, 0);
      check("rst_wrap", {wrap_w, wrap_s}, 0);
      check("rst_tc_up", tc_w, 0);
      up = 1'b0; #1;
      check("rst_tc_down", tc_w, 1);
      up = 1'b1;
      rst_n = 1'b1;
      tick(2);

      // Ten clean pulses counting up, first one with latency check.
      push(4'd1, 1'b0);
      trigger = 1'b1;
      tick(LAT - 1);
      check("lat_before", cnt_w, 0);
      tick(1);
      check("lat_at", cnt_w, 1);
      tick(8 - LAT);
      trigger = 1'b0;
      tick(8);
      for (int i = 2; i <= 10; i++) begin
         push(W'(i % 10), i == 10);
         pulse(8, 8);
         if (i == 9) check("tc_at_max", tc_w, 1);
      end
      check("count_wrapped", cnt_w, 0);
      check("tc_after_wrap", tc_w, 0);
      check("wrap_once", n_wrap_w, 1);
      check("sat_up_hold", cnt_s, 9);
      check("sat_up_tc", tc_s, 1);

      // Load 0, then count down three times.
      load = 1'b1; load_val = '0;
      tick(1);
      load = 1'b0;
      check("load0_w", cnt_w, 0);
      check("load0_s", cnt_s, 0);
      up = 1'b0; #1;
      check("sat_tc_down", tc_s, 1);
      push(4'd9, 1'b1); push(4'd8, 1'b0); push(4'd7, 1'b0);
      ps = n_step_s;
      repeat (3) pulse(8, 8);
      check("sat_down_hold", cnt_s, 0);
      check("sat_steps", n_step_s - ps, 3);
      check("sat_no_wrap", n_wrap_s, 0);
      check("wrap_down", n_wrap_w, 2);

      // Load coincident with a step event.
      up = 1'b1;
      trigger = 1'b1;
      tick(LAT - 1);
      load = 1'b1; load_val = 4'd12;
      push(4'd9, 1'b0);
      tick(1);
      load = 1'b0;
      check("ld_clamp_w", cnt_w, 9);
      check("ld_clamp_s", cnt_s, 9);
      check("ld_no_wrap", wrap_w, 0);
      check("ld_step", step_w, 1);
      tick(8 - LAT);
      trigger = 1'b0;
      tick(8);

      // Disabled counting: steps pulse, count stays, nothing deferred.
      en = 1'b0;
      push(4'd9, 1'b0); push(4'd9, 1'b0);
      pulse(8, 8);
      pulse(8, 8);
      en = 1'b1;
      tick(12);
      check("en_hold", cnt_w, 9);
      check("en_sb_empty", sb_q.size(), 0);

      // Bouncing rise then held high.
      for (int k = 0; k < (DEB_ON ? 1 : 4); k++) push(W'(k), k == 0);
      repeat (3) begin
         trigger = 1'b1; tick(2);
         trigger = 1'b0; tick(2);
      end
      trigger = 1'b1;
      tick(LAT - 1);
      check("bounce_before", cnt_w, DEB_ON ? 9 : 2);
      tick(1);
      check("bounce_at", cnt_w, DEB_ON ? 0 : 3);
      tick(12);
      trigger = 1'b0;
      tick(12);
      check("bounce_sb_empty", sb_q.size(), 0);

      // Reset while an event is still pending.
      ps = n_step_w;
      trigger = 1'b1;
      tick(DEB_ON ? 4 : 2);
      rst_n = 1'b0; trigger = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(16);
      check("midrst_count_w", cnt_w, 0);
      check("midrst_count_s", cnt_s, 0);
      check("midrst_no_step", n_step_w - ps, 0);

      // Trigger held high through reset release counts once.
      rst_n = 1'b0; trigger = 1'b1;
      tick(3);
      rst_n = 1'b1;
      push(4'd1, 1'b0);
      tick(LAT - 1);
      check("rel_before", cnt_w, 0);
      tick(1);
      check("rel_at", cnt_w, 1);
      tick(12);
      trigger = 1'b0;
      tick(12);
      check("rel_once", cnt_w, 1);
      check("rel_s", cnt_s, 1);
      check("final_sb_empty", sb_q.size(), 0);
      check("total_steps", n_step_w, 17 + (DEB_ON ? 1 : 4));
      check("sat_never_wraps", n_wrap_s, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/trig_counter.md
TRIG_COUNTER -- requirements
Module: trig_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 The module SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal count, legal range 1..2**WIDTH-1.
REQ-003 The module SHALL have parameter DEB_CYCLES, default 16: debounce stability window in clk cycles, legal range 2..2**16-1.
REQ-004 The module SHALL have parameter SATURATE, default 0: 0 wraps at the count limits, 1 holds at the count limits.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port trigger, input, 1 bit: asynchronous, possibly bouncing, count request.
REQ-008 The module SHALL have port en, input, 1 bit: count enable.
REQ-009 The module SHALL have port up, input, 1 bit: direction, 1 counts up and 0 counts down.
REQ-010 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-011 The module SHALL have port load_val, input, WIDTH bits: value applied on load.
REQ-012 The module SHALL have port count, output, WIDTH bits: registered counter value.
REQ-013 The module SHALL have port tc, output, 1 bit: terminal-count flag.
REQ-014 The module SHALL have port wrap, output, 1 bit: registered one-cycle pulse on wrap-around.
REQ-015 The module SHALL have port step, output, 1 bit: registered one-cycle pulse per accepted trigger edge.

Function
REQ-016 The block SHALL pass trigger through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-017 With debounce compiled in, the filtered level SHALL take the value of sync2 only after sync2 has differed from it for DEB_CYCLES consecutive clk edges; any mismatch-free sample SHALL clear the stability counter.
REQ-018 A step event SHALL be the rising edge of the filtered level; a falling edge SHALL produce no event.
REQ-019 For a clean trigger rise held high, count SHALL update at rising clk edge 3+DEB_CYCLES after the first edge sampling trigger high (edge 3 without debounce).
REQ-020 Each step event SHALL cause exactly one increment when up=1, or one decrement when up=0, and only if en=1 in that cycle.
REQ-021 load=1 SHALL set count to min(load_val, MAX_VAL) on the next edge regardless of en, overriding a simultaneous step, and SHALL not assert wrap.
REQ-022 On an up-step at count==MAX_VAL, count SHALL go to 0 when SATURATE=0, or hold when SATURATE=1.
REQ-023 On a down-step at count==0, count SHALL go to MAX_VAL when SATURATE=0, or hold when SATURATE=1.
REQ-024 wrap SHALL be high for exactly the one cycle following an edge on which a wrap of REQ-022 or REQ-023 occurred, and SHALL never assert when SATURATE=1.
REQ-025 step SHALL be high for the one cycle following every step event, independent of en and load.
REQ-026 tc SHALL be combinational: (up && count==MAX_VAL) || (!up && count==0).
REQ-027 Changing up or en SHALL take effect on the same edge it is sampled; no event SHALL be queued while en=0.

Reset
REQ-028 While rst_n=0 at a clk edge, count, wrap, step, sync1, sync2, the filtered level and the stability counter SHALL all become 0.
REQ-029 Reset SHALL take priority over load and step.
REQ-030 A trigger held high through reset release SHALL be counted once, at the latency of REQ-019 measured from the first edge with rst_n=1.
REQ-031 Reset asserted mid-debounce SHALL discard the pending event.

Configuration
REQ-032 The macro TRIG_COUNTER_DEBOUNCE_EN defined SHALL compile in the debounce filter of REQ-017.
REQ-033 Without TRIG_COUNTER_DEBOUNCE_EN, the filtered level SHALL equal sync2 and DEB_CYCLES SHALL be ignored; all other behaviour SHALL be unchanged.

Verification (WIDTH=4, MAX_VAL=9, DEB_CYCLES=4, debounce on unless stated)
REQ-034 The bench SHALL cover: reset, then 10 clean trigger pulses (each 8 high / 8 low), up=1, en=1 -> count 1..9 then 0, wrap pulses once, tc high while count==9.
REQ-035 The bench SHALL cover: a trigger rise with 3 bounces of 2 cycles each, then held high -> exactly one step, count update at edge 7 after the last rise.
REQ-036 The bench SHALL cover: count=0, up=0, SATURATE=1, 3 pulses -> count stays 0, wrap never asserts, step pulses 3 times.
REQ-037 The bench SHALL cover: load=1 with load_val=12 coincident with a step edge -> count=9, no wrap, step still pulses.
REQ-038 The bench SHALL cover: en=0 during 2 pulses, then en=1 -> count unchanged, 2 step pulses, no deferred increment.
REQ-039 The bench SHALL cover: macro undefined, single clean pulse -> count updates at edge 3; rst_n=0 mid-debounce (macro defined) -> count 0, no step after release.
